// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle control FSM for the RV32I-subset CPU.
// Steps each instruction through IF/ID/EX/MEM/WB, decodes the IR fields,
// resolves branches from the ALU flags and drives every datapath enable.
// Only the state register and the sticky illegal flag are flops; all
// other outputs decode combinationally from state, IR fields and flags.
module mc_control_unit (
  input  logic       clk,
  input  logic       Reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       PCWre,
  output logic       PCSrc,
  output logic       IRWre,
  output logic       RegWre,
  output logic       ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [2:0] ImmSel,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] WBSel,
  output logic [2:0] state,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_OP,
    CL_OPIMM,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_LUI,
    CL_JAL,
    CL_BAD
  } class_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  class_e     cls;
  logic       taken;

  // Unqualified enables; gated by Reset before leaving the block.
  logic       pc_wre, ir_wre, reg_wre, mem_read, mem_write;
  logic       pc_src, alu_src_b;
  logic [3:0] alu_op;
  logic [2:0] imm_sel;
  logic [1:0] wb_sel;

  // funct3 -> ALU operation; alt_add selects SUB for 000, alt_shift SRA for 101.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                 input logic       alt_add,
                                                 input logic       alt_shift);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = alt_add   ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt_shift ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Instruction class from the opcode; branches with funct3 010/011 are unsupported.
  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cls = CL_BAD;
    case (opcode)
      OPC_OP:     cls = CL_OP;
      OPC_OPIMM:  cls = CL_OPIMM;
      OPC_LOAD:   cls = CL_LOAD;
      OPC_STORE:  cls = CL_STORE;
      OPC_BRANCH: cls = (funct3 == 3'b010 || funct3 == 3'b011) ? CL_BAD : CL_BRANCH;
      OPC_LUI:    cls = CL_LUI;
      OPC_JAL:    cls = CL_JAL;
      default:    cls = CL_BAD;
    endcase
  end

  // Branch condition from the ALU flags of the SUB performed in EX.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  // Next-state and datapath control decode for the current state and class.
  always_comb begin
    state_d   = S_IF;
    illegal_d = illegal_q;
    pc_wre    = 1'b0;
    ir_wre    = 1'b0;
    reg_wre   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pc_src    = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    imm_sel   = IMM_I;
    wb_sel    = WB_ALU;

    case (state_q)
      S_IF: begin
        ir_wre  = 1'b1;
        state_d = S_ID;
      end

      S_ID: begin
        case (cls)
          CL_OP, CL_OPIMM, CL_LOAD, CL_BRANCH: state_d = S_EX;
          CL_STORE: begin
            state_d = S_EX;
            imm_sel = IMM_S;
          end
          CL_LUI: begin
            state_d = S_EX;
            imm_sel = IMM_U;
          end
          CL_JAL: begin
            state_d = S_WB;
            imm_sel = IMM_J;
          end
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end

      S_EX: begin
        case (cls)
          CL_OP: begin
            alu_op  = alu_from_funct3(funct3, funct7_5, funct7_5);
            state_d = S_WB;
          end
          CL_OPIMM: begin
            alu_src_b = 1'b1;
            alu_op    = alu_from_funct3(funct3, 1'b0, funct7_5);
            state_d   = S_WB;
          end
          CL_LUI: begin
            alu_src_b = 1'b1;
            alu_op    = ALU_PASSB;
            state_d   = S_WB;
          end
          CL_LOAD, CL_STORE: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          CL_BRANCH: begin
            alu_op  = ALU_SUB;
            imm_sel = IMM_B;
            pc_wre  = 1'b1;
            pc_src  = taken;
            state_d = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end

      S_MEM: begin
        case (cls)
          CL_LOAD: begin
            mem_read  = 1'b1;
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          CL_STORE: begin
            mem_write = 1'b1;
            imm_sel   = IMM_S;
            pc_wre    = 1'b1;
            state_d   = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end

      S_WB: begin
        reg_wre = 1'b1;
        pc_wre  = 1'b1;
        state_d = S_IF;
        case (cls)
          CL_JAL: begin
            wb_sel  = WB_PC4;
            pc_src  = 1'b1;
            imm_sel = IMM_J;
          end
          CL_LOAD: wb_sel = WB_MEM;
          default: wb_sel = WB_ALU;
        endcase
      end

      S_HALT: state_d = S_HALT;

      // Unused encodings 5 and 6 recover to IF.
      default: state_d = S_IF;
    endcase
  end

  // State register and sticky illegal flag.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IF;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Enables are gated by Reset so nothing writes while reset is held,
  // even though the state register already sits in IF.
  assign PCWre    = pc_wre    & Reset;
  assign IRWre    = ir_wre    & Reset;
  assign RegWre   = reg_wre   & Reset;
  assign MemRead  = mem_read  & Reset;
  assign MemWrite = mem_write & Reset;
  assign PCSrc    = pc_src;
  assign ALUSrcB  = alu_src_b;
  assign ALUOp    = alu_op;
  assign ImmSel   = imm_sel;
  assign WBSel    = wb_sel;
  assign state    = state_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed testbench for mc_control_unit: walks each instruction class
// through its state sequence and compares the control outputs against
// hand-computed values.
`timescale 1ns/1ps
module tb_mc_control_unit;

  logic       clk;
  logic       Reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero, lt, ltu;
  logic       PCWre, PCSrc, IRWre, RegWre, ALUSrcB, MemRead, MemWrite, illegal;
  logic [3:0] ALUOp;
  logic [2:0] ImmSel;
  logic [1:0] WBSel;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  mc_control_unit dut (
    .clk      (clk),
    .Reset    (Reset),
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .zero     (zero),
    .lt       (lt),
    .ltu      (ltu),
    .PCWre    (PCWre),
    .PCSrc    (PCSrc),
    .IRWre    (IRWre),
    .RegWre   (RegWre),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .ImmSel   (ImmSel),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .WBSel    (WBSel),
    .state    (state),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Enable bundle {PCWre, IRWre, RegWre, MemRead, MemWrite}.
  function automatic logic [4:0] enables();
    return {PCWre, IRWre, RegWre, MemRead, MemWrite};
  endfunction

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    opcode   = op;
    funct3   = f3;
    funct7_5 = f75;
  endtask

  // From IF: check IF, advance to ID, check ID, advance into EX.
  task automatic to_ex(input string tag);
    check({tag, "_if_state"}, 32'(state), 32'd0);
    check({tag, "_if_irwre"}, 32'(IRWre), 32'd1);
    step();
    check({tag, "_id_state"}, 32'(state), 32'd1);
    check({tag, "_id_en"}, 32'(enables()), 32'd0);
    step();
  endtask

  initial begin
    Reset = 1'b0;
    set_ir(7'b0010011, 3'b000, 1'b0);
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;

    // Reset state
    #3;
    check("rst_state", 32'(state), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_en", 32'(enables()), 32'd0);
    check("rst_aluop", 32'(ALUOp), 32'd0);
    check("rst_immsel", 32'(ImmSel), 32'd0);
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    #1;

    // ADDI: 0 -> 1 -> 2 -> 4 -> 0
    to_ex("addi");
    check("addi_ex_state", 32'(state), 32'd2);
    check("addi_ex_aluop", 32'(ALUOp), 32'd0);
    check("addi_ex_srcb", 32'(ALUSrcB), 32'd1);
    check("addi_ex_irwre", 32'(IRWre), 32'd0);
    step();
    check("addi_wb_state", 32'(state), 32'd4);
    check("addi_wb_en", 32'(enables()), 32'b10100);
    check("addi_wb_pcsrc", 32'(PCSrc), 32'd0);
    check("addi_wb_wbsel", 32'(WBSel), 32'd0);
    step();
    check("addi_back_if", 32'(state), 32'd0);

    // R-type SRA
    set_ir(7'b0110011, 3'b101, 1'b1);
    to_ex("sra");
    check("sra_aluop", 32'(ALUOp), 32'd7);
    check("sra_srcb", 32'(ALUSrcB), 32'd0);
    step();
    check("sra_wb_state", 32'(state), 32'd4);
    step();

    // R-type SUB
    set_ir(7'b0110011, 3'b000, 1'b1);
    to_ex("sub");
    check("sub_aluop", 32'(ALUOp), 32'd1);
    step(); step();

    // R-type OR
    set_ir(7'b0110011, 3'b110, 1'b0);
    to_ex("or");
    check("or_aluop", 32'(ALUOp), 32'd8);
    step(); step();

    // OP-IMM 000 with funct7_5=1 stays ADD
    set_ir(7'b0010011, 3'b000, 1'b1);
    to_ex("addi7");
    check("addi7_aluop", 32'(ALUOp), 32'd0);
    step(); step();

    // SRAI / SRLI
    set_ir(7'b0010011, 3'b101, 1'b1);
    to_ex("srai");
    check("srai_aluop", 32'(ALUOp), 32'd7);
    step(); step();
    set_ir(7'b0010011, 3'b101, 1'b0);
    to_ex("srli");
    check("srli_aluop", 32'(ALUOp), 32'd6);
    step(); step();

    // LUI
    set_ir(7'b0110111, 3'b000, 1'b0);
    check("lui_if_state", 32'(state), 32'd0);
    step();
    check("lui_id_immsel", 32'(ImmSel), 32'd3);
    step();
    check("lui_ex_aluop", 32'(ALUOp), 32'd10);
    check("lui_ex_srcb", 32'(ALUSrcB), 32'd1);
    step();
    check("lui_wb_state", 32'(state), 32'd4);
    step();

    // BEQ taken
    set_ir(7'b1100011, 3'b000, 1'b0);
    zero = 1'b1;
    to_ex("beq1");
    check("beq1_pcwre", 32'(PCWre), 32'd1);
    check("beq1_pcsrc", 32'(PCSrc), 32'd1);
    check("beq1_immsel", 32'(ImmSel), 32'd2);
    check("beq1_aluop", 32'(ALUOp), 32'd1);
    check("beq1_regwre", 32'(RegWre), 32'd0);
    step();
    check("beq1_next", 32'(state), 32'd0);

    // BEQ not taken
    zero = 1'b0;
    to_ex("beq0");
    check("beq0_pcwre", 32'(PCWre), 32'd1);
    check("beq0_pcsrc", 32'(PCSrc), 32'd0);
    step();

    // BGEU with ltu=0 -> taken
    set_ir(7'b1100011, 3'b111, 1'b0);
    ltu = 1'b0;
    to_ex("bgeu");
    check("bgeu_pcsrc", 32'(PCSrc), 32'd1);
    step();

    // BLTU with ltu=0 -> not taken; BLT with lt=1 -> taken
    set_ir(7'b1100011, 3'b110, 1'b0);
    to_ex("bltu");
    check("bltu_pcsrc", 32'(PCSrc), 32'd0);
    step();
    set_ir(7'b1100011, 3'b100, 1'b0);
    lt = 1'b1;
    to_ex("blt");
    check("blt_pcsrc", 32'(PCSrc), 32'd1);
    step();
    lt = 1'b0;

    // LW: 0 1 2 3 4 0
    set_ir(7'b0000011, 3'b010, 1'b0);
    to_ex("lw");
    check("lw_ex_state", 32'(state), 32'd2);
    check("lw_ex_srcb", 32'(ALUSrcB), 32'd1);
    check("lw_ex_en", 32'(enables()), 32'd0);
    step();
    check("lw_mem_state", 32'(state), 32'd3);
    check("lw_mem_en", 32'(enables()), 32'b00010);
    step();
    check("lw_wb_state", 32'(state), 32'd4);
    check("lw_wb_wbsel", 32'(WBSel), 32'd1);
    check("lw_wb_en", 32'(enables()), 32'b10100);
    step();
    check("lw_next", 32'(state), 32'd0);

    // SW: 0 1 2 3 0, RegWre never set
    set_ir(7'b0100011, 3'b010, 1'b0);
    check("sw_if_state", 32'(state), 32'd0);
    step();
    check("sw_id_immsel", 32'(ImmSel), 32'd1);
    check("sw_id_regwre", 32'(RegWre), 32'd0);
    step();
    check("sw_ex_state", 32'(state), 32'd2);
    check("sw_ex_regwre", 32'(RegWre), 32'd0);
    step();
    check("sw_mem_state", 32'(state), 32'd3);
    check("sw_mem_en", 32'(enables()), 32'b10001);
    check("sw_mem_pcsrc", 32'(PCSrc), 32'd0);
    check("sw_mem_immsel", 32'(ImmSel), 32'd1);
    step();
    check("sw_next", 32'(state), 32'd0);

    // JAL: 0 1 4 0
    set_ir(7'b1101111, 3'b000, 1'b0);
    step();
    check("jal_id_state", 32'(state), 32'd1);
    check("jal_id_immsel", 32'(ImmSel), 32'd4);
    step();
    check("jal_wb_state", 32'(state), 32'd4);
    check("jal_wb_wbsel", 32'(WBSel), 32'd2);
    check("jal_wb_pcsrc", 32'(PCSrc), 32'd1);
    check("jal_wb_immsel", 32'(ImmSel), 32'd4);
    check("jal_wb_en", 32'(enables()), 32'b10100);
    step();
    check("jal_next", 32'(state), 32'd0);

    // Unsupported opcode -> HALT, sticky
    set_ir(7'b1110011, 3'b000, 1'b0);
    step();
    check("ill_id_illegal", 32'(illegal), 32'd0);
    step();
    check("ill_state", 32'(state), 32'd7);
    check("ill_flag", 32'(illegal), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      check("ill_hold_state", 32'(state), 32'd7);
      check("ill_hold_en", 32'(enables()), 32'd0);
    end
    set_ir(7'b0010011, 3'b000, 1'b0);
    step();
    check("ill_sticky", 32'(illegal), 32'd1);

    // Reset clears HALT
    @(negedge clk);
    Reset = 1'b0;
    #1;
    check("rst2_state", 32'(state), 32'd0);
    check("rst2_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    Reset = 1'b1;
    #1;

    // Reset mid-LOAD in MEM
    set_ir(7'b0000011, 3'b010, 1'b0);
    step(); step(); step();
    check("abort_mem_state", 32'(state), 32'd3);
    check("abort_mem_rd", 32'(MemRead), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check("abort_memread", 32'(MemRead), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    check("abort_illegal", 32'(illegal), 32'd0);
    check("abort_en", 32'(enables()), 32'd0);
    step();
    check("abort_hold_state", 32'(state), 32'd0);
    check("abort_hold_en", 32'(enables()), 32'd0);
    @(negedge clk);
    Reset = 1'b1;
    #1;

    // Branch with funct3=010 is unsupported
    set_ir(7'b1100011, 3'b010, 1'b0);
    check("bill_if_irwre", 32'(IRWre), 32'd1);
    step(); step();
    check("bill_state", 32'(state), 32'd7);
    check("bill_flag", 32'(illegal), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule
